ip_fetch_buffer: RTL and testbench

IP_FETCH_BUFFER -- requirements
Module: ip_fetch_buffer

---
 rtl/ip_fetch_buffer.sv | 91 +++++++++
 tb/tb_ip_fetch_buffer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ip_fetch_buffer.sv
// Circular instruction fetch buffer: compacts masked fetch groups in, presents up to WAYS head entries out.
// Pushes are visible one cycle later; fill_ready drops unless a whole group fits (no same-cycle pop credit).
module ip_fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int WAYS  = 2,
    parameter int DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          fill_valid,
    output logic                          fill_ready,
    input  logic [XLEN-1:0]               fill_address,
    input  logic [WAYS*32-1:0]            fill_data,
    input  logic [WAYS-1:0]               fill_mask,
    input  logic                          flush,
    output logic [WAYS-1:0]               out_valid,
    output logic [WAYS*32-1:0]            out_instr,
    output logic [WAYS*XLEN-1:0]          out_address,
    input  logic [$clog2(WAYS+1)-1:0]     out_accept,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]     mem_instr [DEPTH];
    logic [XLEN-1:0] mem_addr  [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] slot_idx [WAYS];
    logic [CW-1:0] push_n;
    logic [CW-1:0] valid_n;
    logic [CW-1:0] pop_n;
    logic          do_push;

    assign fill_ready = ((CW'(DEPTH) - count) >= CW'(WAYS)) && !flush;
    assign do_push    = fill_valid && fill_ready;

    // Each set slot lands at tail plus the number of set slots below it.
    always_comb begin
        push_n = '0;
        for (int i = 0; i < WAYS; i++) begin
            slot_idx[i] = tail + AW'(push_n);
            if (fill_mask[i]) begin
                push_n = push_n + CW'(1);
            end
        end
        valid_n = (count > CW'(WAYS)) ? CW'(WAYS) : count;
        pop_n   = (CW'(out_accept) > valid_n) ? valid_n : CW'(out_accept);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + AW'(push_n);
            end
            head  <= head + AW'(pop_n);
            count <= count + (do_push ? push_n : CW'(0)) - pop_n;
        end
    end

    // Storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            for (int i = 0; i < WAYS; i++) begin
                if (fill_mask[i]) begin
                    mem_instr[slot_idx[i]] <= fill_data[32*i +: 32];
                    mem_addr[slot_idx[i]]  <= fill_address + XLEN'(4*i);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            out_valid[i]               = count > CW'(i);
            out_instr[32*i +: 32]      = mem_instr[head + AW'(i)];
            out_address[XLEN*i +: XLEN] = mem_addr[head + AW'(i)];
        end
    end

endmodule

// File: tb/tb_ip_fetch_buffer.sv
// Directed table-driven bench for ip_fetch_buffer (XLEN=32, WAYS=2, DEPTH=8).
module tb_ip_fetch_buffer;

    logic        clock;
    logic        reset;
    logic        fill_valid;
    logic        fill_ready;
    logic [31:0] fill_address;
    logic [63:0] fill_data;
    logic [1:0]  fill_mask;
    logic        flush;
    logic [1:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_address;
    logic [1:0]  out_accept;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;

    ip_fetch_buffer #(.XLEN(32), .WAYS(2), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_address(fill_address), .fill_data(fill_data), .fill_mask(fill_mask),
        .flush(flush), .out_valid(out_valid), .out_instr(out_instr),
        .out_address(out_address), .out_accept(out_accept), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fv;
        logic        fl;
        logic [1:0]  acc;
        logic [1:0]  mask;
        logic [31:0] addr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        e_ready;
        logic [3:0]  e_count;
        logic [1:0]  e_valid;
        logic [31:0] e_a0;
        logic [31:0] e_i0;
        logic [31:0] e_a1;
        logic [31:0] e_i1;
    } vec_t;

    localparam logic [31:0] IA = 32'h1000_0011, IB = 32'h1000_0022, IC = 32'h1000_0033;
    localparam logic [31:0] ID = 32'h1000_0044, IE = 32'h1000_0055, IF = 32'h1000_0066;
    localparam logic [31:0] IG = 32'h1000_0077, IH = 32'h1000_0088, II = 32'h1000_0099;
    localparam logic [31:0] IJ = 32'h1000_00AA, IK = 32'h1000_00BB, IL = 32'h1000_00CC;
    localparam logic [31:0] IM = 32'h1000_00DD, IN = 32'h1000_00EE, IO = 32'h1000_00FF;
    localparam logic [31:0] IP = 32'h1000_0101, IQ = 32'h1000_0102, IR = 32'h1000_0103;
    localparam logic [31:0] IS = 32'h1000_0104, IT = 32'h1000_0105, IX = 32'hDEAD_BEEF;

    vec_t vec [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic fl, input logic [1:0] acc,
                         input logic [1:0] mask, input logic [31:0] addr,
                         input logic [31:0] d0, input logic [31:0] d1);
        fill_valid   = fv;
        flush        = fl;
        out_accept   = acc;
        fill_mask    = mask;
        fill_address = addr;
        fill_data    = {d1, d0};
    endtask

    initial begin
        vec[0]  = '{1, 0, 0, 2'b11, 32'h100, IA, IB, 1, 2, 2'b11, 32'h100, IA, 32'h104, IB};
        vec[1]  = '{0, 0, 2, 2'b00, 32'h0,   0,  0,  1, 0, 2'b00, 0, 0, 0, 0};
        vec[2]  = '{1, 0, 0, 2'b10, 32'h200, IC, ID, 1, 1, 2'b01, 32'h204, ID, 0, 0};
        vec[3]  = '{0, 0, 2, 2'b00, 32'h0,   0,  0,  1, 0, 2'b00, 0, 0, 0, 0};
        vec[4]  = '{1, 0, 0, 2'b00, 32'h300, IX, IX, 1, 0, 2'b00, 0, 0, 0, 0};
        vec[5]  = '{1, 0, 0, 2'b11, 32'h400, IE, IF, 1, 2, 2'b11, 32'h400, IE, 32'h404, IF};
        vec[6]  = '{1, 0, 0, 2'b11, 32'h408, IG, IH, 1, 4, 2'b11, 32'h400, IE, 32'h404, IF};
        vec[7]  = '{1, 0, 0, 2'b01, 32'h410, II, IX, 1, 5, 2'b11, 32'h400, IE, 32'h404, IF};
        vec[8]  = '{1, 0, 0, 2'b11, 32'h418, IJ, IK, 1, 7, 2'b11, 32'h400, IE, 32'h404, IF};
        vec[9]  = '{1, 0, 0, 2'b11, 32'h420, IL, IM, 0, 7, 2'b11, 32'h400, IE, 32'h404, IF};
        vec[10] = '{1, 0, 1, 2'b11, 32'h420, IL, IM, 0, 6, 2'b11, 32'h404, IF, 32'h408, IG};
        vec[11] = '{1, 0, 0, 2'b11, 32'h420, IL, IM, 1, 8, 2'b11, 32'h404, IF, 32'h408, IG};
        vec[12] = '{0, 0, 2, 2'b00, 32'h0,   0,  0,  0, 6, 2'b11, 32'h40C, IH, 32'h410, II};
        vec[13] = '{0, 0, 1, 2'b00, 32'h0,   0,  0,  1, 5, 2'b11, 32'h410, II, 32'h418, IJ};
        vec[14] = '{0, 0, 2, 2'b00, 32'h0,   0,  0,  1, 3, 2'b11, 32'h41C, IK, 32'h420, IL};
        vec[15] = '{1, 0, 2, 2'b11, 32'h500, IN, IO, 1, 3, 2'b11, 32'h424, IM, 32'h500, IN};
        vec[16] = '{1, 0, 0, 2'b11, 32'h508, IP, IQ, 1, 5, 2'b11, 32'h424, IM, 32'h500, IN};
        vec[17] = '{1, 0, 0, 2'b01, 32'h510, IR, IX, 1, 6, 2'b11, 32'h424, IM, 32'h500, IN};
        vec[18] = '{1, 1, 1, 2'b11, 32'h600, IX, IX, 0, 0, 2'b00, 0, 0, 0, 0};
        vec[19] = '{0, 0, 0, 2'b00, 32'h0,   0,  0,  1, 0, 2'b00, 0, 0, 0, 0};
        vec[20] = '{1, 0, 0, 2'b11, 32'hFFFF_FFFC, IS, IT, 1, 2, 2'b11, 32'hFFFF_FFFC, IS, 32'h0, IT};

        reset = 1'b0;
        drive(0, 0, 0, 2'b00, 32'h0, 0, 0);
        repeat (2) @(negedge clock);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        #1;
        chk("post_reset_ready", 64'(fill_ready), 64'd1);

        // Each vector: drive on the falling edge, check ready before the rising edge, state after it.
        for (int v = 0; v < 21; v++) begin
            drive(vec[v].fv, vec[v].fl, vec[v].acc, vec[v].mask, vec[v].addr, vec[v].d0, vec[v].d1);
            #1;
            chk($sformatf("v%0d_ready", v), 64'(fill_ready), 64'(vec[v].e_ready));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_count", v), 64'(count), 64'(vec[v].e_count));
            chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'(vec[v].e_valid));
            if (vec[v].e_valid[0]) begin
                chk($sformatf("v%0d_addr0", v), 64'(out_address[31:0]), 64'(vec[v].e_a0));
                chk($sformatf("v%0d_instr0", v), 64'(out_instr[31:0]), 64'(vec[v].e_i0));
            end
            if (vec[v].e_valid[1]) begin
                chk($sformatf("v%0d_addr1", v), 64'(out_address[63:32]), 64'(vec[v].e_a1));
                chk($sformatf("v%0d_instr1", v), 64'(out_instr[63:32]), 64'(vec[v].e_i1));
            end
            @(negedge clock);
        end

        // Mid-stream asynchronous reset clears occupancy without waiting for a clock edge.
        drive(1, 0, 0, 2'b11, 32'h700, IA, IB);
        @(posedge clock);
        #1;
        chk("pre_arst_count", 64'(count), 64'd4);
        drive(0, 0, 0, 2'b00, 32'h0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("arst_release_ready", 64'(fill_ready), 64'd1);
        drive(1, 0, 0, 2'b01, 32'h800, IC, IX);
        @(posedge clock);
        #1;
        chk("after_arst_count", 64'(count), 64'd1);
        chk("after_arst_valid", 64'(out_valid), 64'b01);
        chk("after_arst_addr0", 64'(out_address[31:0]), 64'h800);
        chk("after_arst_instr0", 64'(out_instr[31:0]), 64'(IC));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
